// File: rtl/cpu_bus1_master_if.sv
// Request/response port of the bus-1 CPU requester: one word-level request in,
// one completion pulse out.
`timescale 1ns/1ps
interface cpu_bus1_master_if #(
    parameter int ADDR_W = 19,
    parameter int CMD_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    // master = the requesting CPU side, slave = the bus-1 requester block
    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/cpu_bus1_master.sv
// CPU-side bus-1 requester: serialises one request onto the two-cycle A1/D1/C1
// protocol, hands the bus to the cache and returns a one-cycle result pulse.
//
// state   | meaning
// IDLE    | drive C1=NOP, accept a request
// CMD     | C1=cmd, A1={tag,set}, D1=low write word
// ADDR2   | C1=cmd, A1=offset, D1=high (WRITE32) or low write word
// WAIT    | bus released, wait for C1_RESPONSE or timeout
// WAIT_HI | READ32 second response beat
// DONE    | resp_valid pulse, C1 back to NOP
`timescale 1ns/1ps
module cpu_bus1_master #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT           = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    cpu_bus1_master_if.slave          req_if,
    inout  wire [ADDR1_BUS_SIZE-1:0]  io_a1_wire,
    inout  wire [DATA1_BUS_SIZE-1:0]  io_d1_wire,
    inout  wire [CTR1_BUS_SIZE-1:0]   io_c1_wire
);
    localparam int REQ_ADDR_W = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;
    localparam int CNT_W      = $clog2(TIMEOUT + 1);

    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16  = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = CTR1_BUS_SIZE'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR2,
        ST_WAIT,
        ST_WAIT_HI,
        ST_DONE
    } state_t;

    state_t                    r_state;
    logic [CTR1_BUS_SIZE-1:0]  r_cmd;
    logic [REQ_ADDR_W-1:0]     r_addr;
    logic [31:0]               r_wdata;
    logic [CNT_W-1:0]          r_cnt;
    logic [31:0]               r_rdata;
    logic                      r_valid;
    logic                      r_err;
    logic                      r_ready;
    logic                      r_c1_oe;
    logic [CTR1_BUS_SIZE-1:0]  r_c1_out;
    logic                      r_a1_oe;
    logic [ADDR1_BUS_SIZE-1:0] r_a1_out;
    logic                      r_d1_oe;
    logic [DATA1_BUS_SIZE-1:0] r_d1_out;

    logic w_handshake;
    logic w_resp;
    logic w_timeout;
    logic w_req_write;
    logic w_is_write;

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    assign w_handshake = req_if.req_valid & r_ready;
    // an X/Z control bus compares false, so it never counts as a response
    assign w_resp      = (io_c1_wire == C1_RESPONSE);
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));
    assign w_req_write = is_write(req_if.req_cmd);
    assign w_is_write  = is_write(r_cmd);

    assign io_c1_wire = r_c1_oe ? r_c1_out : {CTR1_BUS_SIZE{1'bz}};
    assign io_a1_wire = r_a1_oe ? r_a1_out : {ADDR1_BUS_SIZE{1'bz}};
    assign io_d1_wire = r_d1_oe ? r_d1_out : {DATA1_BUS_SIZE{1'bz}};

    assign req_if.req_ready  = r_ready;
    assign req_if.resp_valid = r_valid;
    assign req_if.resp_rdata = r_rdata;
    assign req_if.resp_err   = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cmd    <= C1_NOP;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_c1_oe  <= 1'b0;
            r_c1_out <= C1_NOP;
            r_a1_oe  <= 1'b0;
            r_a1_out <= '0;
            r_d1_oe  <= 1'b0;
            r_d1_out <= '0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_ready  <= 1'b1;
                    r_c1_oe  <= 1'b1;
                    r_c1_out <= C1_NOP;
                    r_a1_oe  <= 1'b0;
                    r_d1_oe  <= 1'b0;
                    if (w_handshake) begin
                        r_ready <= 1'b0;
                        r_cmd   <= req_if.req_cmd;
                        r_addr  <= req_if.req_addr;
                        r_wdata <= req_if.req_wdata;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        if (req_if.req_cmd == C1_NOP) begin
                            // no bus transaction to run: report an error next cycle
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= ST_CMD;
                            r_c1_out <= req_if.req_cmd;
                            r_a1_oe  <= 1'b1;
                            r_a1_out <= req_if.req_addr[REQ_ADDR_W-1:CACHE_OFFSET_SIZE];
                            r_d1_oe  <= w_req_write;
                            r_d1_out <= req_if.req_wdata[DATA1_BUS_SIZE-1:0];
                        end
                    end
                end
                ST_CMD: begin
                    r_state  <= ST_ADDR2;
                    r_a1_out <= ADDR1_BUS_SIZE'(r_addr[CACHE_OFFSET_SIZE-1:0]);
                    r_d1_oe  <= w_is_write;
                    r_d1_out <= (r_cmd == C1_WRITE32) ?
                                r_wdata[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE] :
                                r_wdata[DATA1_BUS_SIZE-1:0];
                end
                ST_ADDR2: begin
                    r_state <= ST_WAIT;
                    r_c1_oe <= 1'b0;
                    r_a1_oe <= 1'b0;
                    r_d1_oe <= 1'b0;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_resp) begin
                        if (r_cmd == C1_READ32) begin
                            r_rdata[DATA1_BUS_SIZE-1:0] <= io_d1_wire;
                            r_state <= ST_WAIT_HI;
                        end else begin
                            if (r_cmd == C1_READ8)
                                r_rdata <= 32'(io_d1_wire[7:0]);
                            else if (r_cmd == C1_READ16)
                                r_rdata <= 32'(io_d1_wire);
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_c1_oe  <= 1'b1;
                            r_c1_out <= C1_NOP;
                        end
                    end else if (w_timeout) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_c1_oe  <= 1'b1;
                        r_c1_out <= C1_NOP;
                    end
                end
                ST_WAIT_HI: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_resp) begin
                        r_rdata[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE] <= io_d1_wire;
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_c1_oe  <= 1'b1;
                        r_c1_out <= C1_NOP;
                    end else if (w_timeout) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_c1_oe  <= 1'b1;
                        r_c1_out <= C1_NOP;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus1_master.sv
// Directed bench for cpu_bus1_master with a small bus-1 cache model and a
// response scoreboard.
`timescale 1ns/1ps
module tb_cpu_bus1_master;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int OW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wire [AW-1:0] a1_w;
    wire [DW-1:0] d1_w;
    wire [CW-1:0] c1_w;

    logic          tb_c1_en  = 1'b0;
    logic [CW-1:0] tb_c1_val = '0;
    logic          tb_d1_en  = 1'b0;
    logic [DW-1:0] tb_d1_val = '0;

    assign c1_w = tb_c1_en ? tb_c1_val : 3'bz;
    assign d1_w = tb_d1_en ? tb_d1_val : 16'bz;

    cpu_bus1_master_if #(.ADDR_W(AW + OW), .CMD_W(CW)) req_if();

    cpu_bus1_master #(
        .ADDR1_BUS_SIZE(AW), .DATA1_BUS_SIZE(DW), .CTR1_BUS_SIZE(CW),
        .CACHE_OFFSET_SIZE(OW), .TIMEOUT(255)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .req_if(req_if),
        .io_a1_wire(a1_w),
        .io_d1_wire(d1_w),
        .io_c1_wire(c1_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cache_resp(input logic [DW-1:0] d);
        tb_c1_en  = 1'b1;
        tb_c1_val = 3'd7;
        tb_d1_en  = 1'b1;
        tb_d1_val = d;
    endtask

    task automatic cache_off;
        tb_c1_en = 1'b0;
        tb_d1_en = 1'b0;
    endtask

    // Drives one request, optionally books its expected result, and returns
    // one step after the handshake edge (DUT in CMD, or DONE for a NOP cmd).
    task automatic send(input logic [CW-1:0] cmd, input logic [AW+OW-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input bit book);
        exp_t e;
        bit   hs;
        hs = 1'b0;
        req_if.req_valid = 1'b1;
        req_if.req_cmd   = cmd;
        req_if.req_addr  = addr;
        req_if.req_wdata = wd;
        if (book) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            sb.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            hs = req_if.req_ready;
            tick;
            if (hs) break;
        end
        chk1("handshake", hs, 1'b1);
        // scramble the inputs so the bench notices any use of unlatched values
        req_if.req_valid = 1'b0;
        req_if.req_cmd   = ~cmd;
        req_if.req_addr  = ~addr;
        req_if.req_wdata = ~wd;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && req_if.resp_valid) begin
            chk1("resp_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_rdata", req_if.resp_rdata, e.rdata);
                chk1("resp_err", req_if.resp_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit bus_drv;
        lat     = 0;
        bus_drv = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_cmd   = '0;
        req_if.req_addr  = '0;
        req_if.req_wdata = '0;

        // reset
        tick;
        tick;
        chk1("rst_a1_z", a1_w === 15'bz, 1'b1);
        chk1("rst_d1_z", d1_w === 16'bz, 1'b1);
        chk1("rst_c1_z", c1_w === 3'bz, 1'b1);
        chk1("rst_ready", req_if.req_ready, 1'b0);
        chk1("rst_valid", req_if.resp_valid, 1'b0);
        chk("rst_rdata", req_if.resp_rdata, 32'h0);
        chk1("rst_err", req_if.resp_err, 1'b0);
        rst_n = 1'b1;
        tick;
        chk1("c1_driven_first", c1_w === 3'bz, 1'b0);
        chk("c1_nop_first", 32'(c1_w), 32'h0);
        chk1("ready_idle", req_if.req_ready, 1'b1);
        tick;
        tick;
        chk1("idle_a1_z", a1_w === 15'bz, 1'b1);
        chk1("idle_d1_z", d1_w === 16'bz, 1'b1);
        chk("idle_c1", 32'(c1_w), 32'h0);

        // INVALIDATE_LINE, cache answers on WAIT cycle 2
        send(3'd4, 19'h00000, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("inv_cmd_c1", 32'(c1_w), 32'h4);
        chk("inv_cmd_a1", 32'(a1_w), 32'h0);
        chk1("inv_cmd_d1_z", d1_w === 16'bz, 1'b1);
        tick;
        chk("inv_a2_c1", 32'(c1_w), 32'h4);
        chk("inv_a2_a1", 32'(a1_w), 32'h0);
        chk1("inv_a2_d1_z", d1_w === 16'bz, 1'b1);
        tick;
        chk1("inv_rel_c1_z", c1_w === 3'bz, 1'b1);
        chk1("inv_rel_a1_z", a1_w === 15'bz, 1'b1);
        chk1("inv_rel_d1_z", d1_w === 16'bz, 1'b1);
        tick;
        chk1("inv_no_early", req_if.resp_valid, 1'b0);
        cache_resp(16'h0);
        tick;
        cache_off;
        #1;
        chk1("inv_valid", req_if.resp_valid, 1'b1);
        chk("inv_done_c1", 32'(c1_w), 32'h0);
        chk1("inv_done_ready", req_if.req_ready, 1'b0);
        tick;
        chk1("inv_single_pulse", req_if.resp_valid, 1'b0);
        chk1("inv_ready_back", req_if.req_ready, 1'b1);

        // WRITE32
        send(3'd7, 19'h1234A, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        chk("w32_cmd_c1", 32'(c1_w), 32'h7);
        chk("w32_cmd_a1", 32'(a1_w), 32'h1234);
        chk("w32_cmd_d1", 32'(d1_w), 32'hBEEF);
        tick;
        chk("w32_a2_c1", 32'(c1_w), 32'h7);
        chk("w32_a2_a1", 32'(a1_w), 32'hA);
        chk("w32_a2_d1", 32'(d1_w), 32'hDEAD);
        tick;
        chk1("w32_rel_d1_z", d1_w === 16'bz, 1'b1);
        cache_resp(16'h0);
        tick;
        cache_off;
        #1;
        chk1("w32_valid", req_if.resp_valid, 1'b1);
        tick;

        // WRITE8 at the top of the address space
        send(3'd5, 19'h7FFFF, 32'h12345678, 32'h0, 1'b0, 1'b1);
        chk("w8_cmd_a1", 32'(a1_w), 32'h7FFF);
        chk("w8_cmd_d1", 32'(d1_w), 32'h5678);
        tick;
        chk("w8_a2_a1", 32'(a1_w), 32'hF);
        chk("w8_a2_d1", 32'(d1_w), 32'h5678);
        tick;
        cache_resp(16'h0);
        tick;
        cache_off;
        #1;
        tick;

        // READ32, two response beats
        send(3'd3, 19'h00010, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1);
        chk("r32_cmd_c1", 32'(c1_w), 32'h3);
        chk("r32_cmd_a1", 32'(a1_w), 32'h1);
        chk1("r32_cmd_d1_z", d1_w === 16'bz, 1'b1);
        tick;
        chk("r32_a2_a1", 32'(a1_w), 32'h0);
        tick;
        cache_resp(16'h5678);
        tick;
        chk1("r32_no_early", req_if.resp_valid, 1'b0);
        tb_d1_val = 16'h1234;
        tick;
        cache_off;
        #1;
        chk1("r32_valid", req_if.resp_valid, 1'b1);
        tick;

        // READ8, cache answers late
        send(3'd1, 19'h00123, 32'h0, 32'h000000CD, 1'b0, 1'b1);
        tick;
        tick;
        tick;
        tick;
        cache_resp(16'hABCD);
        tick;
        cache_off;
        #1;
        chk1("r8_valid", req_if.resp_valid, 1'b1);
        tick;

        // READ16
        send(3'd2, 19'h00456, 32'h0, 32'h00008001, 1'b0, 1'b1);
        tick;
        tick;
        cache_resp(16'h8001);
        tick;
        cache_off;
        #1;
        tick;

        // NOP command completes at once with an error and no bus activity
        send(3'd0, 19'h00100, 32'hFFFF, 32'h0, 1'b1, 1'b1);
        chk1("nop_valid", req_if.resp_valid, 1'b1);
        chk("nop_c1", 32'(c1_w), 32'h0);
        chk1("nop_a1_z", a1_w === 15'bz, 1'b1);
        chk1("nop_d1_z", d1_w === 16'bz, 1'b1);
        tick;
        chk1("nop_single_pulse", req_if.resp_valid, 1'b0);

        // READ16 with no response: timeout
        send(3'd2, 19'h00200, 32'h0, 32'h0, 1'b1, 1'b1);
        tick;
        tick;
        for (int k = 1; k <= 300; k++) begin
            tick;
            if (req_if.resp_valid) begin
                lat = k;
                break;
            end
            if (!(c1_w === 3'bz)) bus_drv = 1'b1;
        end
        chk("to_latency", 32'(lat), 32'd256);
        chk("to_c1_nop", 32'(c1_w), 32'h0);
        chk1("to_no_c1_drive", bus_drv, 1'b0);
        tick;

        // reset while driving the bus in CMD
        send(3'd1, 19'h00300, 32'h0, 32'h0, 1'b0, 1'b0);
        chk1("rcmd_a1_driven", a1_w === 15'bz, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rcmd_a1_z", a1_w === 15'bz, 1'b1);
        chk1("rcmd_c1_z", c1_w === 3'bz, 1'b1);
        tick;
        rst_n = 1'b1;
        tick;

        // reset during WAIT with a response pending
        send(3'd1, 19'h00400, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        tick;
        cache_resp(16'h1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rwait_ready", req_if.req_ready, 1'b0);
        chk1("rwait_a1_z", a1_w === 15'bz, 1'b1);
        cache_off;
        #1;
        chk1("rwait_c1_z", c1_w === 3'bz, 1'b1);
        tick;
        chk1("rwait_no_valid", req_if.resp_valid, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rwait_c1_nop", 32'(c1_w), 32'h0);

        // READ8 after the reset
        send(3'd1, 19'h00500, 32'h0, 32'h000000EF, 1'b0, 1'b1);
        tick;
        tick;
        cache_resp(16'hBEEF);
        tick;
        cache_off;
        #1;
        chk1("post_rst_valid", req_if.resp_valid, 1'b1);
        tick;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
